// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: debounced single-shot key capture with two-digit multiplexed display
module keypad_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MUX_CYCLES      = 8,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] hex,
  output logic [1:0] an,
  output logic       key_stb,
  output logic [3:0] key_last
);
  typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MUX_LAST = CNT_W'(MUX_CYCLES - 1);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d, mux_cnt_q, mux_cnt_d;
  logic [3:0]       cand_q, cand_d, digit_new_q, digit_new_d, digit_old_q, digit_old_d;
  logic             vld_new_q, vld_new_d, vld_old_q, vld_old_d, sel_q, sel_d, key_stb_q, key_stb_d;
  logic             commit;
  // debounce FSM next state plus history shift on commit
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    cand_d  = cand_q;
    commit  = 1'b0;
    case (state_q)
      IDLE:    if (key_valid) begin
                 cand_d  = key_code;
                 dcnt_d  = '0;
                 state_d = PRESS;
               end
      PRESS:   if (!key_valid || key_code != cand_q) state_d = IDLE;
               else if (dcnt_q == DB_LAST) begin
                 commit  = 1'b1;
                 state_d = HELD;
               end else dcnt_d = dcnt_q + 1'b1;
      HELD:    if (!key_valid) begin
                 dcnt_d  = '0;
                 state_d = RELEASE;
               end
      RELEASE: if (key_valid) state_d = HELD;
               else if (dcnt_q == DB_LAST) state_d = IDLE;
               else dcnt_d = dcnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
    digit_new_d = commit ? cand_q : digit_new_q;
    digit_old_d = commit ? digit_new_q : digit_old_q;
    vld_new_d   = commit ? 1'b1 : vld_new_q;
    vld_old_d   = commit ? vld_new_q : vld_old_q;
    key_stb_d   = commit;
  end
  // free-running digit mux, independent of the FSM
  always_comb begin
    mux_cnt_d = (mux_cnt_q == MUX_LAST) ? '0 : mux_cnt_q + 1'b1;
    sel_d     = sel_q ^ (mux_cnt_q == MUX_LAST);
  end
  // state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dcnt_q      <= '0;
      cand_q      <= '0;
      digit_new_q <= '0;
      digit_old_q <= '0;
      vld_new_q   <= 1'b0;
      vld_old_q   <= 1'b0;
      mux_cnt_q   <= '0;
      sel_q       <= 1'b0;
      key_stb_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      cand_q      <= cand_d;
      digit_new_q <= digit_new_d;
      digit_old_q <= digit_old_d;
      vld_new_q   <= vld_new_d;
      vld_old_q   <= vld_old_d;
      mux_cnt_q   <= mux_cnt_d;
      sel_q       <= sel_d;
      key_stb_q   <= key_stb_d;
    end
  end
  // display drive: blanking only through the anodes, hex always carries the stored digit
  always_comb begin
    hex      = sel_q ? digit_old_q : digit_new_q;
    an       = sel_q ? (vld_old_q ? 2'b01 : 2'b11) : (vld_new_q ? 2'b10 : 2'b11);
    key_stb  = key_stb_q;
    key_last = digit_new_q;
  end
endmodule
